// File: rtl/ft_rx_reader_if.sv
// Signal bundle between the FT600 receive reader and its surroundings:
// FT bus pins (input view plus OE/RD drives), arbiter handshake and the user-side FIFO port.
interface ft_rx_reader_if #(
  parameter int AW = 6
) ();
  logic          usb_rxf;
  logic [31:0]   usb_data_in;
  logic [3:0]    usb_be_in;
  logic          bus_free;
  logic          usb_oe;
  logic          usb_rd;
  logic          bus_busy;
  logic [31:0]   rx_data;
  logic [3:0]    rx_be;
  logic          rx_valid;
  logic          rx_read;
  logic [AW:0]   rx_level;
  logic [31:0]   word_cnt;
  logic          ovf;

  modport master (
    input  usb_rxf, usb_data_in, usb_be_in, bus_free, rx_read,
    output usb_oe, usb_rd, bus_busy, rx_data, rx_be, rx_valid, rx_level, word_cnt, ovf
  );

  modport slave (
    output usb_rxf, usb_data_in, usb_be_in, bus_free, rx_read,
    input  usb_oe, usb_rd, bus_busy, rx_data, rx_be, rx_valid, rx_level, word_cnt, ovf
  );
endinterface

// File: rtl/ft_rx_reader.sv
// FT600 receive-direction master: bursts host words off the FT bus into a show-ahead FIFO
// and hands them to user logic through a valid/read handshake.
module ft_rx_reader #(
  parameter int AW        = 6,
  parameter int BURST_MAX = 32
) (
  input  logic           clk_in,
  input  logic           rst_in,
  ft_rx_reader_if.master bus
);

  localparam int DEPTH = 1 << AW;
  localparam int BW    = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {IDLE, OE, READ, DONE} state_t;

  state_t          state_q;
  logic            oe_q, rd_q, busy_q;
  logic [BW-1:0]   burst_q;

  logic [35:0]     mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]     level_q, level_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            push, pop, full, room, accept;
  logic [35:0]     head;

  assign push   = rd_q & bus.usb_rxf;
  assign pop    = bus.rx_read & (level_q != '0);
  assign full   = (level_q == (AW+1)'(DEPTH));
  assign accept = push & (~full | pop);
  // A burst may only start when a full BURST_MAX words are guaranteed to fit.
  assign room   = (DEPTH - int'(level_q)) >= BURST_MAX;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      oe_q    <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      burst_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.usb_rxf && bus.bus_free && room) begin
            state_q <= OE;
            oe_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        OE: begin
          state_q <= READ;
          rd_q    <= 1'b1;
        end
        READ: begin
          if (!bus.usb_rxf) begin
            state_q <= DONE;
            oe_q    <= 1'b0;
            rd_q    <= 1'b0;
          end else begin
            burst_q <= burst_q + 1'b1;
            if (burst_q == BW'(BURST_MAX - 1)) begin
              state_q <= DONE;
              oe_q    <= 1'b0;
              rd_q    <= 1'b0;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          burst_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (accept) begin
      wptr_d = wptr_q + 1'b1;
      cnt_d  = cnt_q + 32'd1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    case ({accept, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (accept) mem_q[wptr_q] <= {bus.usb_be_in, bus.usb_data_in};
  end

  // Empty FIFO presents zeros so stale storage never leaks out after reset.
  assign head         = mem_q[rptr_q];
  assign bus.rx_data  = (level_q != '0) ? head[31:0]  : 32'd0;
  assign bus.rx_be    = (level_q != '0) ? head[35:32] : 4'd0;
  assign bus.rx_valid = (level_q != '0);
  assign bus.rx_level = level_q;
  assign bus.word_cnt = cnt_q;
  assign bus.ovf      = ovf_q;
  assign bus.usb_oe   = oe_q;
  assign bus.usb_rd   = rd_q;
  assign bus.bus_busy = busy_q;

endmodule

// File: tb/tb_ft_rx_reader.sv
// Directed bench for ft_rx_reader: a counting host feeds bursts while the user side
// pops, stalls and resets; every expectation below is a hand-derived constant.
module tb_ft_rx_reader;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   hostCnt;

  ft_rx_reader_if #(.AW(6)) bus ();

  ft_rx_reader #(.AW(6), .BURST_MAX(32)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Host side of the FT bus: the next word appears only after one was taken.
  task automatic applyStimulus(input int n);
    logic cap;
    for (int i = 0; i < n; i++) begin
      cap = bus.usb_rd & bus.usb_rxf;
      @(posedge clk);
      #1;
      if (cap) begin
        hostCnt++;
        bus.usb_data_in = hostCnt;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    hostCnt          = 0;
    rst_n            = 1'b0;
    bus.usb_rxf      = 1'b0;
    bus.usb_data_in  = 32'd0;
    bus.usb_be_in    = 4'hF;
    bus.bus_free     = 1'b0;
    bus.rx_read      = 1'b0;
    #1;
    checkOutput("rst_oe", bus.usb_oe, 0);
    checkOutput("rst_rd", bus.usb_rd, 0);
    checkOutput("rst_busy", bus.bus_busy, 0);
    checkOutput("rst_valid", bus.rx_valid, 0);
    checkOutput("rst_level", bus.rx_level, 0);
    checkOutput("rst_data", bus.rx_data, 0);
    checkOutput("rst_be", bus.rx_be, 0);
    checkOutput("rst_wcnt", bus.word_cnt, 0);
    checkOutput("rst_ovf", bus.ovf, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] full bursts with counting host");
    bus.usb_rxf  = 1'b1;
    bus.bus_free = 1'b1;
    applyStimulus(1);
    checkOutput("b1_oe", bus.usb_oe, 1);
    checkOutput("b1_oe_rd", bus.usb_rd, 0);
    checkOutput("b1_busy", bus.bus_busy, 1);
    applyStimulus(1);
    checkOutput("b1_read_rd", bus.usb_rd, 1);
    checkOutput("b1_read_oe", bus.usb_oe, 1);
    applyStimulus(31);
    checkOutput("b1_rd31", bus.usb_rd, 1);
    checkOutput("b1_lvl31", bus.rx_level, 31);
    applyStimulus(1);
    checkOutput("b1_done_rd", bus.usb_rd, 0);
    checkOutput("b1_done_oe", bus.usb_oe, 0);
    checkOutput("b1_done_busy", bus.bus_busy, 1);
    checkOutput("b1_level", bus.rx_level, 32);
    checkOutput("b1_wcnt", bus.word_cnt, 32);
    checkOutput("b1_head", bus.rx_data, 0);
    applyStimulus(1);
    checkOutput("b1_idle_busy", bus.bus_busy, 0);
    applyStimulus(1);
    checkOutput("b2_oe", bus.usb_oe, 1);
    applyStimulus(1);
    checkOutput("b2_rd", bus.usb_rd, 1);
    applyStimulus(32);
    checkOutput("b2_done_rd", bus.usb_rd, 0);
    checkOutput("b2_level", bus.rx_level, 64);

    $display("[TB] stall with FIFO full");
    applyStimulus(4);
    checkOutput("stall_oe", bus.usb_oe, 0);
    checkOutput("stall_busy", bus.bus_busy, 0);
    checkOutput("stall_level", bus.rx_level, 64);
    checkOutput("stall_wcnt", bus.word_cnt, 64);
    checkOutput("stall_ovf", bus.ovf, 0);
    for (int i = 0; i < 32; i++) begin
      bus.rx_read = 1'b1;
      checkOutput($sformatf("pop_a%0d", i), bus.rx_data, i);
      applyStimulus(1);
    end
    bus.rx_read = 1'b0;
    checkOutput("pop_a_level", bus.rx_level, 32);
    checkOutput("pop_a_oe", bus.usb_oe, 0);
    applyStimulus(1);
    checkOutput("resume_oe", bus.usb_oe, 1);
    applyStimulus(1);
    applyStimulus(31);
    checkOutput("b3_lvl63", bus.rx_level, 63);

    $display("[TB] push and pop together at level 63");
    bus.rx_read = 1'b1;
    checkOutput("pp63_head", bus.rx_data, 32);
    applyStimulus(1);
    bus.rx_read = 1'b0;
    checkOutput("pp63_level", bus.rx_level, 63);
    checkOutput("pp63_head2", bus.rx_data, 33);
    checkOutput("pp63_rd", bus.usb_rd, 0);
    checkOutput("pp63_wcnt", bus.word_cnt, 96);
    checkOutput("pp63_ovf", bus.ovf, 0);
    bus.usb_rxf = 1'b0;
    for (int j = 33; j < 96; j++) begin
      bus.rx_read = 1'b1;
      checkOutput($sformatf("pop_b%0d", j), bus.rx_data, j);
      applyStimulus(1);
    end
    checkOutput("empty_valid", bus.rx_valid, 0);
    checkOutput("empty_level", bus.rx_level, 0);

    $display("[TB] short burst from empty, host drops rxf");
    bus.usb_rxf = 1'b1;
    applyStimulus(2);
    applyStimulus(1);
    checkOutput("e_push_level", bus.rx_level, 1);
    checkOutput("e_push_valid", bus.rx_valid, 1);
    checkOutput("e_push_head", bus.rx_data, 96);
    applyStimulus(1);
    bus.rx_read = 1'b0;
    checkOutput("e_pp_level", bus.rx_level, 1);
    checkOutput("e_pp_head", bus.rx_data, 97);
    applyStimulus(2);
    bus.usb_be_in = 4'h3;
    applyStimulus(1);
    bus.usb_rxf   = 1'b0;
    bus.usb_be_in = 4'hF;
    checkOutput("short_level", bus.rx_level, 4);
    applyStimulus(1);
    checkOutput("short_rd", bus.usb_rd, 0);
    checkOutput("short_busy", bus.bus_busy, 1);
    checkOutput("short_wcnt", bus.word_cnt, 101);
    applyStimulus(1);
    checkOutput("short_idle", bus.bus_busy, 0);
    for (int k = 0; k < 4; k++) begin
      bus.rx_read = 1'b1;
      checkOutput($sformatf("pop_c%0d", k), bus.rx_data, 97 + k);
      if (k == 3) checkOutput("last_be", bus.rx_be, 4'h3);
      else        checkOutput($sformatf("be_c%0d", k), bus.rx_be, 4'hF);
      applyStimulus(1);
    end
    bus.rx_read = 1'b0;
    checkOutput("short_empty", bus.rx_level, 0);

    $display("[TB] arbiter holds bus");
    bus.bus_free = 1'b0;
    bus.usb_rxf  = 1'b1;
    applyStimulus(3);
    checkOutput("hold_oe", bus.usb_oe, 0);
    checkOutput("hold_rd", bus.usb_rd, 0);
    checkOutput("hold_busy", bus.bus_busy, 0);
    bus.bus_free = 1'b1;
    applyStimulus(1);
    checkOutput("free_oe", bus.usb_oe, 1);
    applyStimulus(2);
    checkOutput("free_rd", bus.usb_rd, 1);
    checkOutput("free_level", bus.rx_level, 1);

    $display("[TB] reset during READ");
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_rd", bus.usb_rd, 0);
    checkOutput("mrst_oe", bus.usb_oe, 0);
    checkOutput("mrst_valid", bus.rx_valid, 0);
    checkOutput("mrst_wcnt", bus.word_cnt, 0);
    checkOutput("mrst_busy", bus.bus_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
